// File: rtl/keypad_scan_if.sv
// Operator keypad bus: column sense and entry clear in, row drive and accepted-key data out.
interface keypad_scan_if;
    logic [3:0]  col_in;
    logic        entry_clr;
    logic [3:0]  row_ctrl;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] entry_data;
    logic        key_held;

    modport master (
        output col_in, entry_clr,
        input  row_ctrl, key_valid, key_code, entry_data, key_held
    );

    modport slave (
        input  col_in, entry_clr,
        output row_ctrl, key_valid, key_code, entry_data, key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner with press/release debounce and a 16-bit entry shift register.
// Define KEYPAD_REPEAT_EN to re-issue the held key every REPEAT_TICKS scan ticks.
module keypad_scan #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_TICKS   = 100
) (
    input logic         CLK,
    input logic         Reset,
    keypad_scan_if.slave kp
);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_TICKS < 1) begin : g_param_check
        $error("keypad_scan: parameter out of range");
    end

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [STB_W-1:0] stable_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       key_row;
    logic [1:0]       key_col;

    logic       tick_c;
    logic       single_c;
    logic       idle_c;
    logic [1:0] col_idx_c;
    logic       accept_c;
    logic       repeat_c;
    logic       shift_c;
    logic [3:0] code_c;

    // Exactly one low column is a key; anything else (idle or ghosting) is "none".
    always_comb begin
        single_c  = 1'b1;
        col_idx_c = 2'd0;
        case (kp.col_in)
            4'b1110: col_idx_c = 2'd0;
            4'b1101: col_idx_c = 2'd1;
            4'b1011: col_idx_c = 2'd2;
            4'b0111: col_idx_c = 2'd3;
            default: single_c  = 1'b0;
        endcase
    end

    assign tick_c   = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign idle_c   = (kp.col_in == 4'hF);
    assign code_c   = {key_row, key_col};
    assign accept_c = tick_c && (state == DEBOUNCE) && single_c && (col_idx_c == key_col)
                      && (stable_cnt == STB_W'(DEBOUNCE_SCANS - 1));
    assign shift_c  = accept_c || repeat_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_TICKS + 1);
    logic [REP_W-1:0] rep_cnt;
    assign repeat_c = tick_c && (state == HELD) && !idle_c
                      && (rep_cnt == REP_W'(REPEAT_TICKS - 1));
`else
    assign repeat_c = 1'b0;
`endif

    // Scan / debounce / hold / release sequencing; every decision happens on a scan tick.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= SCAN;
            div_cnt     <= '0;
            stable_cnt  <= '0;
            row_idx     <= 2'd0;
            kp.row_ctrl <= 4'b1110;
            key_row     <= 2'd0;
            key_col     <= 2'd0;
            kp.key_held <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                case (state)
                    SCAN: begin
                        if (single_c) begin
                            key_row    <= row_idx;
                            key_col    <= col_idx_c;
                            stable_cnt <= '0;
                            state      <= DEBOUNCE;
                        end else begin
                            row_idx     <= row_idx + 2'd1;
                            kp.row_ctrl <= {kp.row_ctrl[2:0], kp.row_ctrl[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (single_c && (col_idx_c == key_col)) begin
                            stable_cnt <= stable_cnt + STB_W'(1);
                            if (accept_c) begin
                                state       <= HELD;
                                kp.key_held <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt     <= '0;
`endif
                            end
                        end else begin
                            state       <= SCAN;
                            row_idx     <= row_idx + 2'd1;
                            kp.row_ctrl <= {kp.row_ctrl[2:0], kp.row_ctrl[3]};
                        end
                    end
                    HELD: begin
                        if (idle_c) begin
                            state      <= RELEASE;
                            stable_cnt <= '0;
                        end
`ifdef KEYPAD_REPEAT_EN
                        else if (repeat_c) rep_cnt <= '0;
                        else               rep_cnt <= rep_cnt + REP_W'(1);
`endif
                    end
                    RELEASE: begin
                        if (!idle_c) begin
                            state   <= HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end else if (stable_cnt == STB_W'(DEBOUNCE_SCANS - 1)) begin
                            state       <= SCAN;
                            kp.key_held <= 1'b0;
                            row_idx     <= row_idx + 2'd1;
                            kp.row_ctrl <= {kp.row_ctrl[2:0], kp.row_ctrl[3]};
                        end else begin
                            stable_cnt <= stable_cnt + STB_W'(1);
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    // Key pulse, code latch and entry shift; a coincident clear keeps only the new key.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            kp.key_valid  <= 1'b0;
            kp.key_code   <= 4'h0;
            kp.entry_data <= 16'h0000;
        end else begin
            kp.key_valid <= shift_c;
            if (accept_c) kp.key_code <= code_c;
            if (kp.entry_clr)
                kp.entry_data <= shift_c ? {12'h000, code_c} : 16'h0000;
            else if (shift_c)
                kp.entry_data <= {kp.entry_data[11:0], code_c};
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: physical keypad model, behavioural reference, per-cycle compare.
module tb_keypad_scan;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned RT = 5;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    keypad_scan_if kp();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_TICKS(RT)) dut (
        .CLK(CLK), .Reset(Reset), .kp(kp)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int d_pulses = 0;

    // physical keypad: pattern seen on the columns while row kp_r is driven
    bit         kp_on = 1'b0;
    logic [1:0] kp_r  = 2'd0;
    logic [3:0] kp_pat = 4'hF;

    // reference model state
    int         m_cyc, m_row, m_kr, m_kc, m_run, m_rep, m_pulses;
    bit         m_pend, m_held, m_rel, m_valid, m_tick;
    logic [3:0] m_code;
    logic [15:0] m_entry;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_step(logic [3:0] col, bit clr, bit rst);
        bit tick, accept, rpt, single, idle;
        int c, code;
        if (rst) begin
            m_cyc = 0; m_row = 0; m_kr = 0; m_kc = 0; m_run = 0; m_rep = 0;
            m_pend = 0; m_held = 0; m_rel = 0; m_valid = 0; m_tick = 0;
            m_code = 4'h0; m_entry = 16'h0000;
            return;
        end
        tick   = (m_cyc % SD) == SD - 1;
        m_cyc++;
        m_tick = tick;
        single = $countones(~col) == 1;
        idle   = (col == 4'hF);
        c = 0;
        for (int i = 0; i < 4; i++) if (!col[i]) c = i;
        accept = 0;
        rpt    = 0;
        if (tick) begin
            if (m_pend) begin
                if (single && c == m_kc) begin
                    m_run++;
                    if (m_run == DB) begin accept = 1; m_pend = 0; m_held = 1; m_rep = 0; end
                end else begin
                    m_pend = 0; m_row = (m_row + 1) % 4;
                end
            end else if (m_held && !m_rel) begin
                if (idle) begin m_rel = 1; m_run = 0; end
                else begin
                    m_rep++;
`ifdef KEYPAD_REPEAT_EN
                    if (m_rep == RT) begin rpt = 1; m_rep = 0; end
`endif
                end
            end else if (m_rel) begin
                if (idle) begin
                    m_run++;
                    if (m_run == DB) begin m_rel = 0; m_held = 0; m_row = (m_row + 1) % 4; end
                end else begin
                    m_rel = 0; m_rep = 0;
                end
            end else begin
                if (single) begin m_pend = 1; m_kr = m_row; m_kc = c; m_run = 0; end
                else m_row = (m_row + 1) % 4;
            end
        end
        code    = m_kr * 4 + m_kc;
        m_valid = accept || rpt;
        if (accept) m_code = 4'(code);
        if (clr) m_entry = (accept || rpt) ? 16'(code) : 16'h0000;
        else if (accept || rpt) m_entry = {m_entry[11:0], 4'(code)};
        if (m_valid) m_pulses++;
    endfunction

    task automatic drive_cols();
        if (kp_on && kp.row_ctrl[kp_r] == 1'b0) kp.col_in = kp_pat;
        else kp.col_in = 4'hF;
    endtask

    // one clock: advance model, clock DUT, compare every output, re-sense columns
    task automatic cycle();
        logic [25:0] act, exp;
        logic [3:0]  er;
        model_step(kp.col_in, kp.entry_clr, Reset);
        @(posedge CLK);
        #1;
        er  = ~(4'b0001 << m_row);
        exp = {m_valid, m_held, m_code, er, m_entry};
        act = {kp.key_valid, kp.key_held, kp.key_code, kp.row_ctrl, kp.entry_data};
        check("cycle{valid,held,code,row,entry}", 32'(act), 32'(exp));
        if (kp.key_valid === 1'b1) d_pulses++;
        drive_cols();
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        cycle();
        Reset = 1'b0;
    endtask

    task automatic set_key(int k);
        kp_on = 1'b1; kp_r = 2'(k / 4); kp_pat = ~(4'b0001 << (k % 4));
        drive_cols();
    endtask

    task automatic release_keys();
        kp_on = 1'b0;
        drive_cols();
    endtask

    task automatic wait_quiet();
        int b = 0;
        while ((m_held || m_pend) && b < 400) begin cycle(); b++; end
        check("quiet_timeout", 32'(m_held || m_pend), 32'd0);
    endtask

    task automatic wait_accept(int k, bit clr_at_accept);
        int p0 = d_pulses;
        int b  = 0;
        set_key(k);
        while (d_pulses == p0 && b < 400) begin
            kp.entry_clr = clr_at_accept && m_pend && (m_run == DB - 1) && ((m_cyc % SD) == SD - 1);
            cycle();
            b++;
        end
        kp.entry_clr = 1'b0;
        check("accept_seen", 32'(d_pulses != p0), 32'd1);
        check("held_on_accept", 32'(kp.key_held), 32'd1);
    endtask

    task automatic press(int k, int hold_ticks, bit clr_at_accept);
        int t = 0;
        int b = 0;
        wait_quiet();
        wait_accept(k, clr_at_accept);
        while (t < hold_ticks) begin cycle(); if (m_tick) t++; end
        release_keys();
        while (kp.key_held !== 1'b0 && b < 400) begin cycle(); b++; end
        check("released", 32'(kp.key_held), 32'd0);
    endtask

    initial begin
        int p0, changes, b;
        logic [3:0] prev_row;
        m_pulses = 0;
        Reset = 1'b1;
        kp.col_in = 4'hF;
        kp.entry_clr = 1'b0;
        cycle();
        do_reset();
        check("rst_row", 32'(kp.row_ctrl), 32'h0000000E);
        check("rst_entry", 32'(kp.entry_data), 32'h0);
        check("rst_held", 32'(kp.key_held), 32'h0);

        // single key 9 (row 2, col 1), held briefly
        p0 = d_pulses;
        press(9, 2, 1'b0);
        check("k9_pulses", 32'(d_pulses - p0), 32'd1);
        check("k9_code", 32'(kp.key_code), 32'h9);
        check("k9_entry", 32'(kp.entry_data), 32'h0009);
        check("k9_model_entry", 32'(m_entry), 32'h0009);

        for (int k = 1; k <= 5; k++) press(k, 1, 1'b0);
        check("seq_entry", 32'(kp.entry_data), 32'h2345);
        check("seq_model_entry", 32'(m_entry), 32'h2345);
        press(7, 1, 1'b1);
        check("clr_accept_entry", 32'(kp.entry_data), 32'h0007);
        check("clr_accept_code", 32'(kp.key_code), 32'h7);

        // bounce: row 0 col 0 low for two ticks only
        wait_quiet();
        p0 = d_pulses;
        set_key(0);
        b = 0;
        while (!(m_pend && m_run == 1) && b < 200) begin cycle(); b++; end
        release_keys();
        run(40);
        check("bounce_pulses", 32'(d_pulses - p0), 32'd0);
        check("bounce_entry", 32'(kp.entry_data), 32'h0007);
        check("bounce_scanning", 32'(m_pend || m_held), 32'd0);

        // ghost pattern on row 1: rows must keep rotating
        p0 = d_pulses;
        kp_on = 1'b1; kp_r = 2'd1; kp_pat = 4'b1100; drive_cols();
        changes = 0;
        prev_row = kp.row_ctrl;
        for (int i = 0; i < 48; i++) begin
            cycle();
            if (kp.row_ctrl !== prev_row) changes++;
            prev_row = kp.row_ctrl;
        end
        release_keys();
        check("ghost_pulses", 32'(d_pulses - p0), 32'd0);
        check("ghost_rotations", 32'(changes), 32'd12);

        // reset during debounce
        set_key(15);
        b = 0;
        while (!m_pend && b < 200) begin cycle(); b++; end
        release_keys();
        do_reset();
        check("rstdb_row", 32'(kp.row_ctrl), 32'h0000000E);
        check("rstdb_entry", 32'(kp.entry_data), 32'h0);
        p0 = d_pulses;
        run(60);
        check("rstdb_no_pulse", 32'(d_pulses - p0), 32'd0);

        // reset during held
        wait_accept(6, 1'b0);
        release_keys();
        do_reset();
        check("rsthd_row", 32'(kp.row_ctrl), 32'h0000000E);
        check("rsthd_held", 32'(kp.key_held), 32'd0);
        check("rsthd_entry", 32'(kp.entry_data), 32'h0);
        p0 = d_pulses;
        run(60);
        check("rsthd_no_pulse", 32'(d_pulses - p0), 32'd0);

        // long hold of key A
        p0 = d_pulses;
        press(10, 20, 1'b0);
`ifdef KEYPAD_REPEAT_EN
        check("hold_pulses", 32'(d_pulses - p0), 32'd5);
        check("hold_entry", 32'(kp.entry_data), 32'hAAAA);
`else
        check("hold_pulses", 32'(d_pulses - p0), 32'd1);
        check("hold_entry", 32'(kp.entry_data), 32'h000A);
`endif

        // randomized traffic: presses, glitches, random column patterns, clears, resets
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: press(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)),
                            1'($urandom_range(0, 1)));
                2: begin
                    kp_on = 1'b1; kp_r = 2'($urandom_range(0, 3)); kp_pat = 4'($urandom_range(0, 15));
                    drive_cols();
                    run(int'($urandom_range(1, 30)));
                    release_keys();
                    run(30);
                end
                3: begin kp.entry_clr = 1'b1; cycle(); kp.entry_clr = 1'b0; run(5); end
                4: run(int'($urandom_range(1, 20)));
                default: begin release_keys(); do_reset(); end
            endcase
        end
        release_keys();
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
